jcs_seq: RTL and testbench
==========================

JCS_SEQ -- requirements
Module: jcs_seq

Interface
REQ-001 Parameter TICKDIV, default 4: CLK cycles per quarter-phase; legal range 1..65535.
REQ-002 CLK  in  1  single system clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 hold  in  1  when high, the quarter-phase divider and all state freeze.
REQ-005 ir  in  8  instruction register contents.
REQ-006 flags  in  4  latched ALU flags {c,a,e,z}.
REQ-007 clke, clks  out  1 each  enable-window and set-window phase signals.
REQ-008 step  out  6  one-hot current step; bit0 = step 1.
REQ-009 bus1, en_iar, en_ram, en_acc, set_iar, set_mar, set_ir, set_acc, set_tmp, set_ram, set_flags  out  1 each  control strobes.
REQ-010 en_reg, set_reg  out  4 each  one-hot general-register enable/set; bit n = Rn.
REQ-011 alu_op  out  3  ALU operation select.

Function
REQ-012 A divider counts 0..TICKDIV-1; on wrap the quarter index q (0..3) advances; hold=1 freezes both.
REQ-013 clke = 1 for q in {0,1,2}; clks = 1 for q = 1 only (clk=1100, clkd=0110).
REQ-014 When q wraps 3->0, step advances 1->2->...->6->1; step is always exactly one-hot.
REQ-015 Every en_* and bus1 output = decoded term AND clke; every set_* output = decoded term AND clks; all are 0 outside those windows.
REQ-016 alu_op = ir[6:4] in ALU step 5; 000 at all other times.
REQ-017 Fetch: step1 bus1, en_iar, set_mar, set_acc; step2 en_ram, set_ir; step3 en_acc, set_iar.
REQ-018 Decode by ir[7:4] with RA = ir[3:2], RB = ir[1:0], one-hot onto en_reg/set_reg.
REQ-019 ALU (ir[7]=1): step4 en RB, set_tmp; step5 en RA, set_acc, set_flags; step6 en_acc, set RB, suppressed when ir[6:4]=111 (CMP).
REQ-020 0000 LOAD: step4 en RA, set_mar; step5 en_ram, set RB.
REQ-021 0001 STORE: step4 en RA, set_mar; step5 en RB, set_ram.
REQ-022 0010 DATA: step4 bus1, en_iar, set_mar, set_acc; step5 en_ram, set RB; step6 en_acc, set_iar.
REQ-023 0011 JMPR: step4 en RB, set_iar.
REQ-024 0100 JMP: step4 en_iar, set_mar; step5 en_ram, set_iar.
REQ-025 0101 JMPIF: step4 bus1, en_iar, set_mar, set_acc; step5 en_acc, set_iar; step6 en_ram, set_iar only if (ir[3:0] & flags) != 0.
REQ-026 0110 CLF: step4 bus1, set_flags.
REQ-027 Opcodes 0111: steps 4-6 produce no strobes (NOP).
REQ-028 ir and flags are sampled combinationally; they are stable by design except across step2 set_ir, which alters decode from step3 onward only.
REQ-029 If hold rises mid-window, outputs freeze at their current values; they resume unchanged when hold falls.

Reset
REQ-030 While reset_n=0, every output = 0; divider = 0; state = step1, q=0.
REQ-031 On deassertion, the step1/q0 decode is visible in the same cycle: clke=1, bus1=1, en_iar=1.
REQ-032 Reset mid-instruction abandons the instruction; there is no drain.

Structure
REQ-033 A shared package jcs_pkg holds opcode constants (LOAD..CLF, ALU_CMP=3'b111) and step indices.
REQ-034 Phase generation (divider, q, clke/clks, step ring) is sub-module jcs_phase; jcs_seq holds the decode.

Verification
REQ-035 TICKDIV=1, reset release: clke over 4 cycles = 1110, clks = 0100, step = 000001 then 000010 at cycle 4.
REQ-036 ir=8'h86 (ADD R1,R2): step4 en_reg=0100, set_tmp; step5 en_reg=0010, alu_op=000, set_acc, set_flags; step6 en_acc, set_reg=0100.
REQ-037 ir=8'hF6 (CMP): step6 shows no en_acc and set_reg=0000.
REQ-038 ir=8'h52 (JMPIF E): flags=0010 gives step6 en_ram+set_iar pulse; flags=1101 gives none.
REQ-039 hold=1 for 10 cycles at step3 q1: clks stays 1 and step stays 000100; release continues at q2.
REQ-040 reset_n pulled low at step5 of STORE: all outputs 0 asynchronously; after release, step=000001.

Source files
------------

// File: rtl/jcs_pkg.sv
// Shared constants and types for the JCS control sequencer: opcodes, step indices,
// quarter-phase encoding and the bundle of decoded control terms.
package jcs_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_DATA  = 4'b0010;
    localparam logic [3:0] OP_JMPR  = 4'b0011;
    localparam logic [3:0] OP_JMP   = 4'b0100;
    localparam logic [3:0] OP_JMPIF = 4'b0101;
    localparam logic [3:0] OP_CLF   = 4'b0110;
    localparam logic [3:0] OP_NOP   = 4'b0111;

    localparam logic [2:0] ALU_CMP  = 3'b111;

    localparam int NUM_STEPS = 6;
    localparam int STEP_1    = 0;
    localparam int STEP_2    = 1;
    localparam int STEP_3    = 2;
    localparam int STEP_4    = 3;
    localparam int STEP_5    = 4;
    localparam int STEP_6    = 5;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quarter_t;

    // Decoded control terms before the clke/clks windows are applied.
    typedef struct packed {
        logic       bus1;
        logic       en_iar;
        logic       en_ram;
        logic       en_acc;
        logic [3:0] en_reg;
        logic       set_iar;
        logic       set_mar;
        logic       set_ir;
        logic       set_acc;
        logic       set_tmp;
        logic       set_ram;
        logic       set_flags;
        logic [3:0] set_reg;
        logic [2:0] alu_op;
    } ctrl_t;

    function automatic logic [3:0] reg_sel(input logic [1:0] r);
        return 4'b0001 << r;
    endfunction

endpackage

// File: rtl/jcs_phase.sv
// Quarter-phase generator: tick divider, quarter index and the six-step one-hot ring,
// with the clke/clks windows derived from the quarter index.
module jcs_phase
    import jcs_pkg::*;
#(
    parameter int TICKDIV = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 hold_i,
    output logic                 clke_o,
    output logic                 clks_o,
    output logic [NUM_STEPS-1:0] step_o
);

    localparam logic [15:0] DIV_MAX = 16'(TICKDIV - 1);

    logic [15:0]          cnt_q, cnt_d;
    quarter_t             q_q, q_d;
    logic [NUM_STEPS-1:0] step_q, step_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            q_q    <= Q0;
            step_q <= NUM_STEPS'(1);
        end else begin
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            step_q <= step_d;
        end
    end

    // Divider wrap advances the quarter; the quarter wrapping 3->0 advances the step.
    always_comb begin
        cnt_d  = cnt_q;
        q_d    = q_q;
        step_d = step_q;
        if (!hold_i) begin
            if (cnt_q == DIV_MAX) begin
                cnt_d = '0;
                q_d   = quarter_t'(q_q + 2'd1);
                if (q_q == Q3) begin
                    step_d = {step_q[NUM_STEPS-2:0], step_q[NUM_STEPS-1]};
                end
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        clke_o = (q_q != Q3);
        clks_o = (q_q == Q1);
        step_o = step_q;
    end

endmodule

// File: rtl/jcs_seq.sv
// Control sequencer top: decodes the current step and instruction register into
// enable/set strobes, gated by the clke/clks windows and forced low during reset.
module jcs_seq
    import jcs_pkg::*;
#(
    parameter int TICKDIV = 4
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       hold,
    input  logic [7:0] ir,
    input  logic [3:0] flags,
    output logic       clke,
    output logic       clks,
    output logic [5:0] step,
    output logic       bus1,
    output logic       en_iar,
    output logic       en_ram,
    output logic       en_acc,
    output logic       set_iar,
    output logic       set_mar,
    output logic       set_ir,
    output logic       set_acc,
    output logic       set_tmp,
    output logic       set_ram,
    output logic       set_flags,
    output logic [3:0] en_reg,
    output logic [3:0] set_reg,
    output logic [2:0] alu_op
);

    logic                 clke_w, clks_w;
    logic [NUM_STEPS-1:0] step_w;
    logic [3:0]           ra, rb;
    logic                 en_win, set_win;
    ctrl_t                dec;

    jcs_phase #(.TICKDIV(TICKDIV)) u_phase (
        .clk_i  (CLK),
        .rst_ni (reset_n),
        .hold_i (hold),
        .clke_o (clke_w),
        .clks_o (clks_w),
        .step_o (step_w)
    );

    assign ra = reg_sel(ir[3:2]);
    assign rb = reg_sel(ir[1:0]);

    always_comb begin
        dec = '0;
        if (step_w[STEP_1]) begin
            dec.bus1    = 1'b1;
            dec.en_iar  = 1'b1;
            dec.set_mar = 1'b1;
            dec.set_acc = 1'b1;
        end
        if (step_w[STEP_2]) begin
            dec.en_ram = 1'b1;
            dec.set_ir = 1'b1;
        end
        if (step_w[STEP_3]) begin
            dec.en_acc  = 1'b1;
            dec.set_iar = 1'b1;
        end
        if (ir[7]) begin
            if (step_w[STEP_4]) begin
                dec.en_reg  = rb;
                dec.set_tmp = 1'b1;
            end
            if (step_w[STEP_5]) begin
                dec.en_reg    = ra;
                dec.set_acc   = 1'b1;
                dec.set_flags = 1'b1;
                dec.alu_op    = ir[6:4];
            end
            // CMP only updates flags, so the write-back step is suppressed.
            if (step_w[STEP_6] && (ir[6:4] != ALU_CMP)) begin
                dec.en_acc  = 1'b1;
                dec.set_reg = rb;
            end
        end else begin
            case (ir[7:4])
                OP_LOAD: begin
                    if (step_w[STEP_4]) begin dec.en_reg = ra; dec.set_mar = 1'b1; end
                    if (step_w[STEP_5]) begin dec.en_ram = 1'b1; dec.set_reg = rb; end
                end
                OP_STORE: begin
                    if (step_w[STEP_4]) begin dec.en_reg = ra; dec.set_mar = 1'b1; end
                    if (step_w[STEP_5]) begin dec.en_reg = rb; dec.set_ram = 1'b1; end
                end
                OP_DATA: begin
                    if (step_w[STEP_4]) begin
                        dec.bus1    = 1'b1;
                        dec.en_iar  = 1'b1;
                        dec.set_mar = 1'b1;
                        dec.set_acc = 1'b1;
                    end
                    if (step_w[STEP_5]) begin dec.en_ram = 1'b1; dec.set_reg = rb; end
                    if (step_w[STEP_6]) begin dec.en_acc = 1'b1; dec.set_iar = 1'b1; end
                end
                OP_JMPR: begin
                    if (step_w[STEP_4]) begin dec.en_reg = rb; dec.set_iar = 1'b1; end
                end
                OP_JMP: begin
                    if (step_w[STEP_4]) begin dec.en_iar = 1'b1; dec.set_mar = 1'b1; end
                    if (step_w[STEP_5]) begin dec.en_ram = 1'b1; dec.set_iar = 1'b1; end
                end
                OP_JMPIF: begin
                    if (step_w[STEP_4]) begin
                        dec.bus1    = 1'b1;
                        dec.en_iar  = 1'b1;
                        dec.set_mar = 1'b1;
                        dec.set_acc = 1'b1;
                    end
                    if (step_w[STEP_5]) begin dec.en_acc = 1'b1; dec.set_iar = 1'b1; end
                    if (step_w[STEP_6] && ((ir[3:0] & flags) != 4'b0000)) begin
                        dec.en_ram  = 1'b1;
                        dec.set_iar = 1'b1;
                    end
                end
                OP_CLF: begin
                    if (step_w[STEP_4]) begin dec.bus1 = 1'b1; dec.set_flags = 1'b1; end
                end
                default: ;
            endcase
        end
    end

    // reset_n also gates combinationally so outputs drop the moment reset asserts.
    assign en_win  = reset_n & clke_w;
    assign set_win = reset_n & clks_w;

    assign clke      = reset_n & clke_w;
    assign clks      = reset_n & clks_w;
    assign step      = step_w & {NUM_STEPS{reset_n}};
    assign bus1      = dec.bus1 & en_win;
    assign en_iar    = dec.en_iar & en_win;
    assign en_ram    = dec.en_ram & en_win;
    assign en_acc    = dec.en_acc & en_win;
    assign en_reg    = dec.en_reg & {4{en_win}};
    assign set_iar   = dec.set_iar & set_win;
    assign set_mar   = dec.set_mar & set_win;
    assign set_ir    = dec.set_ir & set_win;
    assign set_acc   = dec.set_acc & set_win;
    assign set_tmp   = dec.set_tmp & set_win;
    assign set_ram   = dec.set_ram & set_win;
    assign set_flags = dec.set_flags & set_win;
    assign set_reg   = dec.set_reg & {4{set_win}};
    assign alu_op    = dec.alu_op & {3{reset_n}};

endmodule

// File: tb/tb_jcs_seq.sv
// Bench for jcs_seq: two instances (TICKDIV=3 and TICKDIV=1) checked every cycle against
// a time-based reference model derived from elapsed unheld cycles since reset.
module tb_jcs_seq;

    localparam int TD_A = 3;
    localparam int TD_B = 1;

    typedef struct packed {
        logic       clke;
        logic       clks;
        logic [5:0] step;
        logic       bus1;
        logic       en_iar;
        logic       en_ram;
        logic       en_acc;
        logic [3:0] en_reg;
        logic       set_iar;
        logic       set_mar;
        logic       set_ir;
        logic       set_acc;
        logic       set_tmp;
        logic       set_ram;
        logic       set_flags;
        logic [3:0] set_reg;
        logic [2:0] alu_op;
    } out_t;

    logic       CLK;
    logic       reset_n;
    logic       hold;
    logic [7:0] ir;
    logic [3:0] flags;

    logic       clke_a, clks_a, bus1_a, en_iar_a, en_ram_a, en_acc_a;
    logic       set_iar_a, set_mar_a, set_ir_a, set_acc_a, set_tmp_a, set_ram_a, set_flags_a;
    logic [5:0] step_a;
    logic [3:0] en_reg_a, set_reg_a;
    logic [2:0] alu_op_a;

    logic       clke_b, clks_b, bus1_b, en_iar_b, en_ram_b, en_acc_b;
    logic       set_iar_b, set_mar_b, set_ir_b, set_acc_b, set_tmp_b, set_ram_b, set_flags_b;
    logic [5:0] step_b;
    logic [3:0] en_reg_b, set_reg_b;
    logic [2:0] alu_op_b;

    out_t obs_a, obs_b;
    int   n;
    int   compared;
    int   mismatched;

    jcs_seq #(.TICKDIV(TD_A)) u_a (
        .CLK(CLK), .reset_n(reset_n), .hold(hold), .ir(ir), .flags(flags),
        .clke(clke_a), .clks(clks_a), .step(step_a), .bus1(bus1_a),
        .en_iar(en_iar_a), .en_ram(en_ram_a), .en_acc(en_acc_a),
        .set_iar(set_iar_a), .set_mar(set_mar_a), .set_ir(set_ir_a), .set_acc(set_acc_a),
        .set_tmp(set_tmp_a), .set_ram(set_ram_a), .set_flags(set_flags_a),
        .en_reg(en_reg_a), .set_reg(set_reg_a), .alu_op(alu_op_a)
    );

    jcs_seq #(.TICKDIV(TD_B)) u_b (
        .CLK(CLK), .reset_n(reset_n), .hold(hold), .ir(ir), .flags(flags),
        .clke(clke_b), .clks(clks_b), .step(step_b), .bus1(bus1_b),
        .en_iar(en_iar_b), .en_ram(en_ram_b), .en_acc(en_acc_b),
        .set_iar(set_iar_b), .set_mar(set_mar_b), .set_ir(set_ir_b), .set_acc(set_acc_b),
        .set_tmp(set_tmp_b), .set_ram(set_ram_b), .set_flags(set_flags_b),
        .en_reg(en_reg_b), .set_reg(set_reg_b), .alu_op(alu_op_b)
    );

    assign obs_a = {clke_a, clks_a, step_a, bus1_a, en_iar_a, en_ram_a, en_acc_a, en_reg_a,
                    set_iar_a, set_mar_a, set_ir_a, set_acc_a, set_tmp_a, set_ram_a,
                    set_flags_a, set_reg_a, alu_op_a};
    assign obs_b = {clke_b, clks_b, step_b, bus1_b, en_iar_b, en_ram_b, en_acc_b, en_reg_b,
                    set_iar_b, set_mar_b, set_ir_b, set_acc_b, set_tmp_b, set_ram_b,
                    set_flags_b, set_reg_b, alu_op_b};

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: phase position follows from unheld cycles since reset release.
    function automatic out_t model(input int td, input int cyc, input logic rn,
                                   input logic [7:0] irv, input logic [3:0] fl);
        out_t       o;
        int         q;
        int         s;
        logic [3:0] ra;
        logic [3:0] rb;
        o = '0;
        if (!rn) return o;
        q  = (cyc / td) % 4;
        s  = (cyc / (4 * td)) % 6;
        ra = 4'(1 << irv[3:2]);
        rb = 4'(1 << irv[1:0]);
        o.clke = (q != 3);
        o.clks = (q == 1);
        o.step = 6'(1 << s);
        case (s)
            0: begin o.bus1 = 1; o.en_iar = 1; o.set_mar = 1; o.set_acc = 1; end
            1: begin o.en_ram = 1; o.set_ir = 1; end
            2: begin o.en_acc = 1; o.set_iar = 1; end
            default: begin
                if (irv[7]) begin
                    if (s == 3) begin o.en_reg = rb; o.set_tmp = 1; end
                    if (s == 4) begin o.en_reg = ra; o.set_acc = 1; o.set_flags = 1; o.alu_op = irv[6:4]; end
                    if (s == 5 && irv[6:4] != 3'b111) begin o.en_acc = 1; o.set_reg = rb; end
                end else begin
                    case (irv[6:4])
                        3'd0: begin
                            if (s == 3) begin o.en_reg = ra; o.set_mar = 1; end
                            if (s == 4) begin o.en_ram = 1; o.set_reg = rb; end
                        end
                        3'd1: begin
                            if (s == 3) begin o.en_reg = ra; o.set_mar = 1; end
                            if (s == 4) begin o.en_reg = rb; o.set_ram = 1; end
                        end
                        3'd2: begin
                            if (s == 3) begin o.bus1 = 1; o.en_iar = 1; o.set_mar = 1; o.set_acc = 1; end
                            if (s == 4) begin o.en_ram = 1; o.set_reg = rb; end
                            if (s == 5) begin o.en_acc = 1; o.set_iar = 1; end
                        end
                        3'd3: if (s == 3) begin o.en_reg = rb; o.set_iar = 1; end
                        3'd4: begin
                            if (s == 3) begin o.en_iar = 1; o.set_mar = 1; end
                            if (s == 4) begin o.en_ram = 1; o.set_iar = 1; end
                        end
                        3'd5: begin
                            if (s == 3) begin o.bus1 = 1; o.en_iar = 1; o.set_mar = 1; o.set_acc = 1; end
                            if (s == 4) begin o.en_acc = 1; o.set_iar = 1; end
                            if (s == 5 && (irv[3:0] & fl) != 4'b0) begin o.en_ram = 1; o.set_iar = 1; end
                        end
                        3'd6: if (s == 3) begin o.bus1 = 1; o.set_flags = 1; end
                        default: ;
                    endcase
                end
            end
        endcase
        if (!o.clke) begin
            o.bus1 = 0; o.en_iar = 0; o.en_ram = 0; o.en_acc = 0; o.en_reg = '0;
        end
        if (!o.clks) begin
            o.set_iar = 0; o.set_mar = 0; o.set_ir = 0; o.set_acc = 0; o.set_tmp = 0;
            o.set_ram = 0; o.set_flags = 0; o.set_reg = '0;
        end
        return o;
    endfunction

    // Scoreboard comparison for both instances
    task automatic check(input string tag);
        out_t ea;
        out_t eb;
        ea = model(TD_A, n, reset_n, ir, flags);
        eb = model(TD_B, n, reset_n, ir, flags);
        compared++;
        assert (obs_a === ea) else begin
            mismatched++;
            $error("FAIL %s dutA cyc=%0d ir=%h got=%h exp=%h", tag, n, ir, obs_a, ea);
        end
        compared++;
        assert (obs_b === eb) else begin
            mismatched++;
            $error("FAIL %s dutB cyc=%0d ir=%h got=%h exp=%h", tag, n, ir, obs_b, eb);
        end
    endtask

    // Driver: one clock, advance model time, sample on the falling edge
    task automatic tick(input string tag);
        @(posedge CLK);
        if (reset_n && !hold) n++;
        @(negedge CLK);
        check(tag);
    endtask

    task automatic ticks(input int cnt, input string tag);
        for (int i = 0; i < cnt; i++) tick(tag);
    endtask

    task automatic wait_a(input int st, input int qt, input string tag);
        int k;
        k = 0;
        while (!(((n / (4 * TD_A)) % 6 == st) && ((n / TD_A) % 4 == qt)) && k < 200) begin
            tick(tag);
            k++;
        end
        compared++;
        assert (k < 200) else begin
            mismatched++;
            $error("FAIL %s wait got=%0d cycles required<200", tag, k);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        n          = 0;
        reset_n    = 1'b0;
        hold       = 1'b0;
        ir         = 8'h86;
        flags      = 4'b0000;

        ticks(3, "reset_zero");

        // Release between edges; step1/q0 decode must be visible at once.
        reset_n = 1'b1;
        #1 check("release");
        ticks(4 * 6 * TD_A, "add_r1_r2");

        ir = 8'hF6;
        ticks(4 * 6 * TD_A, "cmp");

        ir    = 8'h52;
        flags = 4'b0010;
        ticks(4 * 6 * TD_A, "jmpif_taken");
        flags = 4'b1101;
        ticks(4 * 6 * TD_A, "jmpif_not");

        ir = 8'h2B;
        ticks(4 * 6 * TD_A, "data");

        // Hold frozen in the set window of step3.
        wait_a(2, 1, "to_s3q1");
        hold = 1'b1;
        ticks(10, "hold");
        hold = 1'b0;
        ticks(2 * 4 * TD_A, "hold_resume");

        // Asynchronous reset in the middle of STORE step5.
        ir = 8'h1B;
        wait_a(4, 1, "to_store_s5");
        #2 reset_n = 1'b0;
        n = 0;
        #1 check("async_reset");
        ticks(2, "in_reset");
        reset_n = 1'b1;
        #1 check("rerelease");
        ticks(8, "after_reset");

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0) ir = 8'($urandom);
            if ($urandom_range(0, 7) == 0) flags = 4'($urandom_range(0, 15));
            hold    = ($urandom_range(0, 7) == 0);
            reset_n = ($urandom_range(0, 149) != 0);
            if (!reset_n) n = 0;
            tick("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
